// File: rtl/atomrvcore_loader_pkg.sv
// atomrvcore_loader_pkg: shared state encoding and byte/word geometry for the ICCM boot loader
package atomrvcore_loader_pkg;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR, CKSUM} loader_state_e;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/atomrvcore_byte_packer.sv
// atomrvcore_byte_packer: valid/ready byte intake packed little-endian into 32-bit words
// Ports: clk_i/rst_i clock and sync reset; clr restarts assembly; ready is the loader's
// registered byte_ready; data/valid is the byte stream; word_valid pulses with word on the
// cycle the last byte of a word is accepted.
module atomrvcore_byte_packer
    import atomrvcore_loader_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr,
    input  logic                         ready,
    input  logic [BYTE_W-1:0]            data,
    input  logic                         valid,
    output logic                         word_valid,
    output logic [WORD_BYTES*BYTE_W-1:0] word
);
    logic [$clog2(WORD_BYTES)-1:0] byte_cnt;
    logic [WORD_BYTES*BYTE_W-1:0]  asm_q;
    logic                          accept;

    assign accept     = valid && ready;
    assign word_valid = accept && (&byte_cnt);

    // The final byte is merged combinationally so the word is usable in its acceptance cycle.
    always_comb begin
        word = asm_q;
        word[byte_cnt*BYTE_W +: BYTE_W] = data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            asm_q[byte_cnt*BYTE_W +: BYTE_W] <= data;
        end
    end
endmodule

// File: rtl/atomrvcore_iccm_loader.sv
// atomrvcore_iccm_loader: boot-time byte-stream loader that fills the ICCM and then releases the PC
// Ports: clk_i/rst_i clock and sync active-high reset; start_i/len_i begin a load of len_i words;
// byte_i/byte_valid_i/byte_ready_o byte stream handshake; IWR_EN_o/address_o/DATA_o ICCM write;
// IR_EN_o ICCM read enable; PCrst_o fetch PC reset; busy_o/done_o/err_o load status.
// Option: define LOADER_CHECKSUM_EN to require a trailing 32-bit sum word after the data.
module atomrvcore_iccm_loader
    import atomrvcore_loader_pkg::*;
#(
    parameter int                    DATAWIDTH   = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  IWR_EN_o,
    output logic                  IR_EN_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATAWIDTH-1:0]  DATA_o,
    output logic                  PCrst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CW = $clog2(DEPTH_WORDS) + 1;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e TAIL = CKSUM;
`else
    localparam loader_state_e TAIL = DONE;
`endif

    loader_state_e        state, state_n;
    logic [CW-1:0]        word_cnt, len_q;
    logic                 word_valid, start_ok;
    logic [DATAWIDTH-1:0] word;
`ifdef LOADER_CHECKSUM_EN
    logic [DATAWIDTH-1:0] sum_q;
`endif

    assign start_ok = state == IDLE && start_i;

    atomrvcore_byte_packer u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr        (start_ok),
        .ready      (byte_ready_o),
        .data       (byte_i),
        .valid      (byte_valid_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_i) state_n = len_i == '0 ? TAIL :
                                          len_i > ADDR_WIDTH'(DEPTH_WORDS) ? ERR : RECV;
            RECV:  if (word_valid) state_n = WRITE;
            WRITE: state_n = word_cnt + CW'(1) == len_q ? TAIL : RECV;
`ifdef LOADER_CHECKSUM_EN
            CKSUM: if (word_valid) state_n = word == sum_q ? DONE : ERR;
`endif
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            word_cnt     <= '0;
            len_q        <= '0;
            byte_ready_o <= 1'b0;
            IWR_EN_o     <= 1'b0;
            IR_EN_o      <= 1'b0;
            address_o    <= BASE_ADDR;
            DATA_o       <= '0;
            PCrst_o      <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_n;
            byte_ready_o <= state_n == RECV || state_n == CKSUM;
            busy_o       <= state_n == RECV || state_n == CKSUM || state_n == WRITE;
            IWR_EN_o     <= state_n == WRITE;
            IR_EN_o      <= state_n == DONE;
            done_o       <= state_n == DONE;
            PCrst_o      <= state_n != DONE;
            err_o        <= state_n == ERR;
            if (start_ok) begin
                len_q    <= CW'(len_i);
                word_cnt <= '0;
            end
            if (state == WRITE) word_cnt <= word_cnt + CW'(1);
            if (state_n == WRITE) begin
                address_o <= BASE_ADDR + ADDR_WIDTH'({word_cnt, 2'b00});
                DATA_o    <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) sum_q <= '0;
        else if (state == WRITE) sum_q <= sum_q + DATA_o;
    end
`endif
endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
// tb_atomrvcore_iccm_loader: table-driven and randomized checks of the ICCM loader against a stream model
module tb_atomrvcore_iccm_loader;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] len_i = '0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o, IWR_EN_o, IR_EN_o, PCrst_o, busy_o, done_o, err_o;
    logic [31:0] address_o, DATA_o;

    atomrvcore_iccm_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .IWR_EN_o     (IWR_EN_o),
        .IR_EN_o      (IR_EN_o),
        .address_o    (address_o),
        .DATA_o       (DATA_o),
        .PCrst_o      (PCrst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] len; int gap; bit ok; } vec_t;

    int          checks = 0;
    int          passed = 0;
    wr_t         wq[$];
    logic [7:0]  bs[$];
    logic [7:0]  nom[8];
    vec_t        vecs[8];

    always @(negedge clk_i) if (IWR_EN_o) wq.push_back('{address_o, DATA_o});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        bs.delete();
        wq.delete();
    endtask

    task automatic start_load(input logic [31:0] len);
        start_i = 1'b1;
        len_i = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        bit acc = 1'b0;
        byte_valid_i = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        byte_valid_i = 1'b1;
        byte_i = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            rdy = byte_ready_o;
            tick();
            acc = rdy;
        end
        byte_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout: got no acceptance, want acceptance of 0x%0h", b);
        end
    endtask

    task automatic send_data(input logic [7:0] b, input int gap);
        bs.push_back(b);
        send_byte(b, gap);
    endtask

    function automatic logic [31:0] exp_word(input int i);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w += 32'(bs[4*i+k]) * (32'd1 << (8*k));
        return w;
    endfunction

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s = '0;
        for (int i = 0; i < bs.size() / 4; i++) s += exp_word(i);
        for (int k = 0; k < 4; k++) send_byte(8'(s >> (8*k)), 0);
`endif
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(done_o || err_o); i++) tick();
    endtask

    task automatic check_writes(input string tag);
        int n = bs.size() / 4;
        check({tag, ".nwr"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, ".addr"}, wq[i].a, 64'(4*i));
            check({tag, ".data"}, wq[i].d, exp_word(i));
        end
    endtask

    task automatic check_end(input string tag, input bit ok);
        check({tag, ".status"}, {done_o, err_o, PCrst_o, IR_EN_o, busy_o, byte_ready_o},
              ok ? 6'b100100 : 6'b011000);
    endtask

    task automatic run_load(input string tag, input logic [31:0] len, input int gap, input bit ok);
        do_reset();
        start_load(len);
        if (ok) begin
            for (int i = 0; i < int'(len) * 4; i++)
                send_data(8'($urandom), gap == 0 ? 0 : int'($urandom_range(0, gap)));
            finish_load();
        end
        wait_end();
        check_end(tag, ok);
        check_writes(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        nom = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        vecs[0] = '{32'd2, 0, 1'b1};
        vecs[1] = '{32'd2, 2, 1'b1};
        vecs[2] = '{32'd0, 0, 1'b1};
        vecs[3] = '{32'd1025, 0, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 0, 1'b0};
        vecs[5] = '{32'd1024, 0, 1'b1};
        vecs[6] = '{32'd1, 3, 1'b1};
        vecs[7] = '{32'd5, 2, 1'b1};

        do_reset();
        check("rst.flags", {PCrst_o, IWR_EN_o, IR_EN_o, byte_ready_o, busy_o, done_o, err_o}, 7'b1000000);
        check("rst.addr", address_o, 0);
        check("rst.data", DATA_o, 0);

        byte_valid_i = 1'b1;
        byte_i = 8'h55;
        tick();
        tick();
        check("idle.noack", {byte_ready_o, busy_o}, 2'b00);
        byte_valid_i = 1'b0;

        start_load(2);
        check("recv.flags", {byte_ready_o, busy_o, PCrst_o}, 3'b111);
        for (int i = 0; i < 4; i++) send_data(nom[i], 0);
        check("lat.n1", {IWR_EN_o, byte_ready_o}, 2'b10);
        check("w0", {address_o, DATA_o}, {32'h0, 32'h0000_0013});
        tick();
        check("lat.n2", {IWR_EN_o, byte_ready_o}, 2'b01);
        for (int i = 4; i < 8; i++) send_data(nom[i], 0);
        check("w1", {address_o, DATA_o}, {32'h4, 32'h0010_0093});
`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) send_byte(k == 0 ? 8'hA6 : k == 2 ? 8'h10 : 8'h00, 0);
`endif
        wait_end();
        check_end("nominal", 1'b1);
        check_writes("nominal");
        start_load(1);
        byte_valid_i = 1'b1;
        tick();
        tick();
        byte_valid_i = 1'b0;
        check_end("done.ignore", 1'b1);
        check("done.nwr", 64'(wq.size()), 2);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        start_load(2);
        for (int i = 0; i < 8; i++) send_data(nom[i], 0);
        for (int k = 0; k < 4; k++) send_byte(k == 0 ? 8'hA7 : k == 2 ? 8'h10 : 8'h00, 0);
        wait_end();
        check_end("cksum.bad", 1'b0);
        check_writes("cksum.bad");
`endif

        do_reset();
        start_load(2);
        for (int i = 0; i < 8; i++) send_data(nom[i], 1);
        finish_load();
        wait_end();
        check_end("bubble", 1'b1);
        check_writes("bubble");

        do_reset();
        start_load(0);
`ifndef LOADER_CHECKSUM_EN
        check("len0.lat", {done_o, IWR_EN_o}, 2'b10);
`endif
        finish_load();
        wait_end();
        check_end("len0", 1'b1);
        check("len0.nwr", 64'(wq.size()), 0);

        do_reset();
        start_load(2);
        for (int i = 0; i < 6; i++) send_data(nom[i], 0);
        do_reset();
        check("midrst.flags", {PCrst_o, IWR_EN_o, IR_EN_o, byte_ready_o, busy_o, done_o, err_o}, 7'b1000000);
        check("midrst.addr", address_o, 0);
        start_load(1);
        for (int i = 0; i < 4; i++) send_data(8'($urandom), 0);
        finish_load();
        wait_end();
        check_end("midrst.reload", 1'b1);
        check_writes("midrst.reload");

        do_reset();
        start_load(2);
        for (int i = 0; i < 2; i++) send_data(nom[i], 0);
        start_i = 1'b1;
        len_i = 0;
        tick();
        start_i = 1'b0;
        check("recv.start_ignored", {busy_o, byte_ready_o, done_o, err_o}, 4'b1100);
        for (int i = 2; i < 8; i++) send_data(nom[i], 0);
        finish_load();
        wait_end();
        check_end("recv.start", 1'b1);
        check_writes("recv.start");

        for (int v = 0; v < 8; v++)
            run_load($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].ok);

        for (int r = 0; r < 6; r++)
            run_load($sformatf("rand%0d", r), 32'($urandom_range(1, 8)), 3, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
